// File: rtl/key_step_counter_pkg.sv
// key_step_counter_pkg: shared FSM state encoding and default saturation bound
package key_step_counter_pkg;
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;
    localparam int MAX_VALUE_DEF = 9999;
endpackage

// File: rtl/key_step_counter_debounce.sv
// key_debounce: 2-FF synchroniser plus stability counter for one active-low button
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic pressed
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic s1, s2;
    logic [CW-1:0] cnt;
    // synchronise, then flip the level only after a full run of differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            pressed <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw_n;
            s2 <= s1;
            if ((!s2) == pressed) cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                pressed <= !s2;
                cnt <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/key_step_counter.sv
// key_step_counter: debounced add/sub/clear buttons driving a saturating 0..MAX_VALUE counter with auto-repeat
module key_step_counter
    import key_step_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES = 8388608,
    parameter int REPEAT_CYCLES = 2097152,
    parameter int MAX_VALUE = MAX_VALUE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        add_n,
    input  logic        sub_n,
    input  logic        clr_n,
    output logic [15:0] value,
    output logic        changed
);
    localparam int TMAX = HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    logic add, sub, clr, dir, go_up, at_lim, held, other, step;
    logic [TW-1:0] timer;
    logic [15:0] step_val;
    state_t state;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_add (.clk(clk), .rst(rst), .raw_n(add_n), .pressed(add));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sub (.clk(clk), .rst(rst), .raw_n(sub_n), .pressed(sub));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (.clk(clk), .rst(rst), .raw_n(clr_n), .pressed(clr));

    // step decision: direction, saturation and whether this cycle steps at all
    always_comb begin
        go_up = state == IDLE ? add : dir;
        at_lim = go_up ? value == 16'(MAX_VALUE) : value == 16'd0;
        step_val = go_up ? value + 16'd1 : value - 16'd1;
        held = dir ? add : sub;
        other = dir ? sub : add;
        step = !clr && ((state == IDLE && add != sub) ||
                        (state == HOLD && held && !other && timer == TW'(HOLD_CYCLES - 1)) ||
                        (state == REPEAT && held && !other && timer == TW'(REPEAT_CYCLES - 1)));
    end

    // FSM, hold/repeat timer and the saturating value register with its change pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            dir <= 1'b0;
            value <= '0;
            changed <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (clr) begin
                state <= IDLE;
                timer <= '0;
                value <= '0;
                changed <= value != 16'd0;
            end else begin
                if (step && !at_lim) begin
                    value <= step_val;
                    changed <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        timer <= '0;
                        dir <= add;
                        state <= add && sub ? LOCK : (add || sub) ? HOLD : IDLE;
                    end
                    HOLD: begin
                        state <= !held ? IDLE : other ? LOCK : step ? REPEAT : HOLD;
                        timer <= step ? '0 : timer + 1'b1;
                    end
                    REPEAT: begin
                        state <= !held ? IDLE : other ? LOCK : REPEAT;
                        timer <= step ? '0 : timer + 1'b1;
                    end
                    default: state <= (!add && !sub) ? IDLE : LOCK;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_key_step_counter.sv
// tb_key_step_counter: directed table-driven checks of stepping, repeat, saturation, lock, clear and reset
module tb_key_step_counter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic add_n = 1'b1, sub_n = 1'b1, clr_n = 1'b1;
    logic [15:0] value;
    logic changed;
    int total = 0, bad = 0, pulses = 0;

    typedef struct {
        logic a;
        logic s;
        logic c;
        int   n;
        int   v;
        int   p;
    } rec_t;
    rec_t vec[$];

    key_step_counter #(
        .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(5), .MAX_VALUE(9999)
    ) dut (
        .clk(clk), .rst(rst), .add_n(add_n), .sub_n(sub_n), .clr_n(clr_n),
        .value(value), .changed(changed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (changed) pulses++;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_rec(input logic a, input logic s, input logic c, input int n, input int v, input int p);
        rec_t r;
        r.a = a; r.s = s; r.c = c; r.n = n; r.v = v; r.p = p;
        vec.push_back(r);
    endtask

    task automatic tap(input bit up, input int v, input int p);
        add_rec(!up, up, 1'b1, 10, v, p);
        add_rec(1'b1, 1'b1, 1'b1, 10, v, 0);
    endtask

    initial begin
        int p0;
        int log_e[$];
        // saturation at the top, clear, saturation at the bottom
        add_rec(1'b0, 1'b1, 1'b1, 50100, 9999, 9988);
        add_rec(1'b1, 1'b1, 1'b1, 10, 9999, 0);
        tap(1'b1, 9999, 0);
        add_rec(1'b1, 1'b1, 1'b0, 10, 0, 1);
        add_rec(1'b1, 1'b1, 1'b1, 10, 0, 0);
        tap(1'b0, 0, 0);
        // lock: sub held into repeat, then add pressed as well
        for (int i = 1; i <= 5; i++) tap(1'b1, i, 1);
        add_rec(1'b1, 1'b0, 1'b1, 28, 3, 2);
        add_rec(1'b0, 1'b0, 1'b1, 12, 2, 1);
        add_rec(1'b1, 1'b0, 1'b1, 20, 2, 0);
        add_rec(1'b1, 1'b1, 1'b1, 10, 2, 0);
        tap(1'b0, 1, 1);
        // clear while add repeats, then add counts as a fresh press after clear release
        add_rec(1'b0, 1'b1, 1'b1, 224, 42, 41);
        add_rec(1'b0, 1'b1, 1'b0, 6, 43, 1);
        add_rec(1'b0, 1'b1, 1'b0, 1, 0, 1);
        add_rec(1'b0, 1'b1, 1'b0, 30, 0, 0);
        add_rec(1'b0, 1'b1, 1'b1, 6, 0, 0);
        add_rec(1'b0, 1'b1, 1'b1, 1, 1, 1);
        add_rec(1'b1, 1'b1, 1'b1, 10, 1, 0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_value", value, 0);
        check("reset_changed", changed, 0);

        // single tap: step lands on the 7th edge, single pulse
        p0 = pulses;
        add_n = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            if (e == 6) check("tap_before_edge7", value, 0);
            if (e == 7) check("tap_edge7_value", value, 1);
            if (e == 7) check("tap_edge7_changed", changed, 1);
            if (e == 8) check("tap_edge8_changed", changed, 0);
        end
        add_n = 1'b1;
        repeat (10) @(negedge clk);
        check("tap_value", value, 1);
        check("tap_pulses", pulses - p0, 1);

        // bounce shorter than the debounce window is ignored
        p0 = pulses;
        for (int k = 0; k < 10; k++) begin
            add_n = 1'b0;
            repeat (2) @(negedge clk);
            add_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("bounce_value", value, 1);
        check("bounce_pulses", pulses - p0, 0);

        // hold: steps at +0, +20, then every 5 up to +60
        p0 = pulses;
        add_n = 1'b0;
        for (int e = 1; e <= 90; e++) begin
            if (e == 64) add_n = 1'b1;
            @(negedge clk);
            if (changed) log_e.push_back(e);
        end
        check("hold_steps", log_e.size(), 10);
        for (int i = 0; i < 10; i++)
            check($sformatf("hold_edge%0d", i), i < log_e.size() ? log_e[i] : -1,
                  i == 0 ? 7 : 27 + 5 * (i - 1));
        check("hold_value", value, 11);
        check("hold_pulses", pulses - p0, 10);

        for (int i = 0; i < vec.size(); i++) begin
            add_n = vec[i].a;
            sub_n = vec[i].s;
            clr_n = vec[i].c;
            p0 = pulses;
            repeat (vec[i].n) @(negedge clk);
            check($sformatf("vec%0d_value", i), value, vec[i].v);
            check($sformatf("vec%0d_pulses", i), pulses - p0, vec[i].p);
        end

        // reset in the middle of a hold clears at once and forces a re-debounce
        add_n = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_value", value, 2);
        check("pre_rst_changed", changed, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_value", value, 0);
        check("rst_async_changed", changed, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            if (e == 6) check("rst_redebounce_wait", value, 0);
            if (e == 7) check("rst_redebounce_step", value, 1);
        end
        add_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
